// File: rtl/count_pkg.sv
// Shared types and helpers for the count_check sequence checker.
package count_pkg;

    localparam int GOOD_W = 4;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    // Increment modulo 2^w, w up to 32.
    function automatic logic [31:0] next_val(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// W-bit event counter; SAT selects saturate-at-max versus wrap-around.
module sat_counter #(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic at_max;
    assign at_max = &o_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count <= '0;
        end else if (i_inc && !(SAT && at_max)) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule

// File: rtl/count_check.sv
// Up-counter sequence checker: hunt, sync, lock, flag breaks.
// Optional COUNT_CHECK_STICKY_EN adds o_sticky, set by any o_error pulse.
module count_check
    import count_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int ERR_W    = 8,
    parameter int SYNC_LEN = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_state,
    output logic             o_locked,
    output logic             o_error,
    output logic [ERR_W-1:0] o_err_count,
    output logic [ERR_W-1:0] o_wraps,
    output logic [WIDTH-1:0] o_expected
`ifdef COUNT_CHECK_STICKY_EN
    ,
    output logic             o_sticky
`endif
);

    state_t              fsm_q, fsm_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [WIDTH-1:0]    exp_val;
    logic [GOOD_W-1:0]   good_q, good_d, good_inc;
    logic                error_q, error_d;
    logic                err_inc, wrap_inc;
    logic                match;

    assign exp_val  = WIDTH'(next_val(32'(prev_q), WIDTH));
    assign match    = (i_state == exp_val);
    assign good_inc = good_q + GOOD_W'(1);

    always_comb begin
        fsm_d    = fsm_q;
        prev_d   = prev_q;
        good_d   = good_q;
        error_d  = 1'b0;
        err_inc  = 1'b0;
        wrap_inc = 1'b0;
        if (i_enable) begin
            prev_d = i_state;
            unique case (fsm_q)
                HUNT: begin
                    good_d = '0;
                    fsm_d  = SYNC;
                end
                SYNC: begin
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc >= GOOD_W'(SYNC_LEN)) fsm_d = LOCK;
                    end else begin
                        good_d = '0;
                    end
                end
                LOCK: begin
                    if (match) begin
                        wrap_inc = &prev_q;
                    end else begin
                        error_d = 1'b1;
                        err_inc = 1'b1;
                        good_d  = '0;
                        fsm_d   = SYNC;
                    end
                end
                default: fsm_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fsm_q   <= HUNT;
            prev_q  <= '0;
            good_q  <= '0;
            error_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            prev_q  <= prev_d;
            good_q  <= good_d;
            error_q <= error_d;
        end
    end

    sat_counter #(.W(ERR_W), .SAT(1'b1)) u_err (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (err_inc),
        .o_count (o_err_count)
    );

    sat_counter #(.W(ERR_W), .SAT(1'b0)) u_wrap (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (wrap_inc),
        .o_count (o_wraps)
    );

    assign o_locked   = (fsm_q == LOCK);
    assign o_error    = error_q;
    assign o_expected = exp_val;

`ifdef COUNT_CHECK_STICKY_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_sticky <= 1'b0;
        else if (error_q) o_sticky <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_count_check.sv
// Self-checking bench for count_check: vector table, corner sequences, random run.
module tb_count_check;

    localparam int WIDTH    = 4;
    localparam int ERR_W    = 8;
    localparam int SYNC_LEN = 2;
    localparam int WMOD     = 1 << WIDTH;
    localparam int EMAX     = (1 << ERR_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_enable;
    logic [WIDTH-1:0] i_state;
    logic             o_locked;
    logic             o_error;
    logic [ERR_W-1:0] o_err_count;
    logic [ERR_W-1:0] o_wraps;
    logic [WIDTH-1:0] o_expected;
`ifdef COUNT_CHECK_STICKY_EN
    logic             o_sticky;
`endif

    count_check #(.WIDTH(WIDTH), .ERR_W(ERR_W), .SYNC_LEN(SYNC_LEN)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_state     (i_state),
        .o_locked    (o_locked),
        .o_error     (o_error),
        .o_err_count (o_err_count),
        .o_wraps     (o_wraps),
        .o_expected  (o_expected)
`ifdef COUNT_CHECK_STICKY_EN
        ,
        .o_sticky    (o_sticky)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: "have a reference", run length of good steps, lock flag.
    bit m_have, m_locked, m_error, m_sticky;
    int m_prev, m_run, m_err, m_wraps;

    function automatic void m_reset();
        m_have = 0; m_locked = 0; m_error = 0; m_sticky = 0;
        m_prev = 0; m_run = 0; m_err = 0; m_wraps = 0;
    endfunction

    function automatic int m_exp();
        return (m_prev + 1) % WMOD;
    endfunction

    function automatic void m_step(bit en, int st);
        if (m_error) m_sticky = 1;
        m_error = 0;
        if (!en) return;
        if (!m_have) begin
            m_have = 1;
            m_run  = 0;
        end else if (m_locked) begin
            if (st == m_exp()) begin
                if (st == 0) m_wraps = (m_wraps + 1) % (EMAX + 1);
            end else begin
                m_error  = 1;
                m_err    = (m_err < EMAX) ? m_err + 1 : EMAX;
                m_locked = 0;
                m_run    = 0;
            end
        end else begin
            if (st == m_exp()) begin
                m_run++;
                if (m_run >= SYNC_LEN) m_locked = 1;
            end else begin
                m_run = 0;
            end
        end
        m_prev = st;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic apply(input bit en, input int st);
        i_enable = en;
        i_state  = WIDTH'(st);
        @(posedge i_clk);
        m_step(en, st);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " locked"}, int'(o_locked), int'(m_locked));
        chk({tag, " error"}, int'(o_error), int'(m_error));
        chk({tag, " err_count"}, int'(o_err_count), m_err);
        chk({tag, " wraps"}, int'(o_wraps), m_wraps);
        chk({tag, " expected"}, int'(o_expected), m_exp());
`ifdef COUNT_CHECK_STICKY_EN
        chk({tag, " sticky"}, int'(o_sticky), int'(m_sticky));
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " locked"}, int'(o_locked), 0);
        chk({tag, " error"}, int'(o_error), 0);
        chk({tag, " err_count"}, int'(o_err_count), 0);
        chk({tag, " wraps"}, int'(o_wraps), 0);
        chk({tag, " expected"}, int'(o_expected), 1);
`ifdef COUNT_CHECK_STICKY_EN
        chk({tag, " sticky"}, int'(o_sticky), 0);
`endif
    endtask

    typedef struct {
        bit en;
        int st;
        bit lk;
        bit er;
        int ec;
        int wr;
        int ex;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int src;
        int st;
        bit en;

        tbl[0]  = '{1, 0,  0, 0, 0, 0, 1};
        tbl[1]  = '{1, 1,  0, 0, 0, 0, 2};
        tbl[2]  = '{1, 2,  1, 0, 0, 0, 3};
        tbl[3]  = '{0, 7,  1, 0, 0, 0, 3};
        tbl[4]  = '{1, 13, 0, 1, 1, 0, 14};
        tbl[5]  = '{1, 14, 0, 0, 1, 0, 15};
        tbl[6]  = '{1, 15, 1, 0, 1, 0, 0};
        tbl[7]  = '{1, 0,  1, 0, 1, 1, 1};
        tbl[8]  = '{1, 1,  1, 0, 1, 1, 2};
        tbl[9]  = '{1, 5,  0, 1, 2, 1, 6};
        tbl[10] = '{1, 5,  0, 0, 2, 1, 6};
        tbl[11] = '{1, 6,  0, 0, 2, 1, 7};
        tbl[12] = '{1, 7,  1, 0, 2, 1, 8};
        tbl[13] = '{1, 4,  0, 1, 3, 1, 5};
        tbl[14] = '{1, 4,  0, 0, 3, 1, 5};
        tbl[15] = '{1, 4,  0, 0, 3, 1, 5};
        tbl[16] = '{1, 5,  0, 0, 3, 1, 6};
        tbl[17] = '{1, 6,  1, 0, 3, 1, 7};

        i_rst = 1'b1; i_enable = 1'b0; i_state = '0;
        m_reset();
        #12;
        check_reset_vals("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].en, tbl[i].st);
            chk($sformatf("vec%0d locked", i), int'(o_locked), int'(tbl[i].lk));
            chk($sformatf("vec%0d error", i), int'(o_error), int'(tbl[i].er));
            chk($sformatf("vec%0d err_count", i), int'(o_err_count), tbl[i].ec);
            chk($sformatf("vec%0d wraps", i), int'(o_wraps), tbl[i].wr);
            chk($sformatf("vec%0d expected", i), int'(o_expected), tbl[i].ex);
        end

        // Saturate the error counter with idle cycles interleaved.
        src = 6;
        for (int k = 0; k < 300; k++) begin
            src = (src + 5) % WMOD;
            apply(1, src);
            check_model("sat_bad");
            apply(0, (src + 3) % WMOD);
            check_model("sat_idle");
            src = (src + 1) % WMOD;
            apply(1, src);
            src = (src + 1) % WMOD;
            apply(1, src);
            check_model("sat_relock");
        end
        chk("sat_final err_count", int'(o_err_count), EMAX);
        chk("sat_final locked", int'(o_locked), 1);

        // Random run: mostly counting, occasional jumps and idle cycles.
        for (int k = 0; k < 2000; k++) begin
            en = ($urandom_range(0, 3) != 0);
            st = src;
            if ($urandom_range(0, 9) == 0) st = $urandom_range(0, WMOD - 1);
            apply(en, st);
            check_model("rand");
            if (en) src = (st + 1) % WMOD;
        end

        // Reset asserted mid-lock returns to reset values immediately.
        apply(1, src);
        src = (src + 1) % WMOD;
        apply(1, src);
        src = (src + 1) % WMOD;
        apply(1, src);
        chk("prelock locked", int'(o_locked), 1);
        #2;
        i_rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        m_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        apply(1, 9);
        check_model("post_rst_seed");
        chk("post_rst_seed expected", int'(o_expected), 10);
        apply(1, 10);
        apply(1, 11);
        check_model("post_rst_lock");
        chk("post_rst_lock locked", int'(o_locked), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
